instr_encoder: RTL
==================

# instr_encoder

Sequential LEGv8 instruction encoder and instruction-memory loader. It accepts one symbolic instruction per handshake (an operation kind plus register and immediate fields) and encodes it into a 32-bit machine word using the same opcode set the main decoder recognises. It then writes the word into consecutive instruction-memory locations. It is the producer side of the instruction stream: it fills the memory that the fetch/decode path later reads.

## Interface
- `DEPTH`, default 64: instruction-memory words the loader may fill.
- `AW`, default $clog2(DEPTH): write-address width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `start` in 1: one-cycle pulse; (re)starts a load session at address 0.
- `in_valid` in 1: input instruction valid.
- `in_ready` out 1: encoder can accept.
- `in_kind` in 4: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 ADDI, 8 SUBI; 9–15 illegal.
- `in_rd` in 5: Rd, or Rt for LDUR/STUR/CBZ.
- `in_rn` in 5: Rn.
- `in_rm` in 5: Rm, used by R-format only.
- `in_imm` in 19: immediate, DT address, or CB offset.
- `in_last` in 1: marks the final instruction of the session.
- `wr_en` out 1: memory write strobe.
- `wr_addr` out AW: word address.
- `wr_data` out 32: encoded instruction.
- `count` out AW+1: words written this session.
- `done` out 1: session finished.
- `err_illegal` out 1: sticky flag, illegal kind seen.
- `err_range` out 1: sticky flag, immediate out of range.

## Operation
- FSM states:
  - IDLE: after reset.
  - LOAD.
  - DONE.
- `start` in any state: go to LOAD; clear pointer, `count`, `done`, `err_illegal`, `err_range`; `in_ready`=0 that cycle, so no accept.
- `in_ready` = (state==LOAD) && (pointer < DEPTH).
- Accept = `in_valid` && `in_ready`.
- Encodings (opcode bits MSB first):
  - R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): [31:21] opcode, [20:16] Rm, [15:10] 0, [9:5] Rn, [4:0] Rd.
  - D (LDUR 11111000010, STUR 11111000000): [31:21] opcode, [20:12] imm[8:0], [11:10] 00, [9:5] Rn, [4:0] Rt.
  - CB (CBZ 10110100): [31:24] opcode, [23:5] imm[18:0], [4:0] Rt.
  - I (ADDI 1001000100, SUBI 1101000100): [31:22] opcode, [21:10] imm[11:0], [9:5] Rn, [4:0] Rd.
- Range rules:
  - I: imm[18:12] must be 0 (unsigned 12-bit).
  - D: imm[18:8] must be all-0 or all-1 (signed 9-bit).
  - CB and R: always in range; R ignores imm.
- Illegal kind or out-of-range immediate:
  - The word is consumed but not written.
  - The matching sticky flag is set.
  - Pointer and `count` are unchanged.
- Legal word: written at the current pointer; pointer and `count` increment by 1.
- State moves to DONE when either:
  - `in_last` is accepted (even if that word errored), or
  - pointer reaches DEPTH.
- DONE holds until `start`.
- Reset mid-session: all state returns to reset values immediately; no partial write completes.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0.
  - `count` 0, `done` 0, `err_illegal` 0, `err_range` 0.
- Latency: accept at edge t → `wr_en`=1 with `wr_addr`/`wr_data` registered during cycle t+1. `wr_en` is a single-cycle pulse per legal word.
- Throughput: one instruction per cycle, with no bubbles while `in_valid` stays high.
- `count` and error flags update at the same edge as the registered write.
- `done` rises at that edge too, coincident with the final `wr_en` if that word is legal.
- `in_ready` is combinational from registered state. It drops in the cycle after the DEPTH-th accept or the `in_last` accept.
- `wr_data` holds its last value when `wr_en`=0.

## Test plan
- ADD X1,X2,X3 (kind 0, rd 1, rn 2, rm 3) → next cycle `wr_en`=1, `wr_addr`=0, `wr_data`=0x8B030041, `count`=1.
- Back-to-back stream, each word checked:
  - LDUR X9,[X0,#8] → 0xF8408009 @ addr 0.
  - CBZ X5,imm=0x7FFFE (−2) → 0xB4FFFFC5 @ addr 1.
  - ADDI X2,X2,#4095 with `in_last` → 0x913FFC42 @ addr 2.
  - Then `done`=1, `in_ready`=0.
- ADDI imm 4096, then kind 12 → no `wr_en`; `err_range`=1, `err_illegal`=1; `count` unchanged; next legal word lands at the same address.
- DEPTH=4, five valid words offered → writes to addr 0..3; `in_ready`=0 after the 4th accept; fifth word never accepted; `done`=1; `count`=4.
- `start` pulse after 2 writes, with `in_valid` high in the same cycle → that input not accepted; next accepted word written at addr 0; flags cleared; `count` restarts at 1.
- Drive `reset`=0 between accept and write → `wr_en` stays 0, all outputs at reset values; after release, state IDLE and `in_ready`=0 until `start`.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: LEGv8 symbolic-instruction encoder that streams words into instruction memory
module instr_encoder #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rn,
    input  logic [4:0]    in_rm,
    input  logic [18:0]   in_imm,
    input  logic          in_last,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err_illegal,
    output logic          err_range
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          err_ill_q, err_ill_d;
    logic          err_rng_q, err_rng_d;
    logic [31:0]   word;
    logic          illegal, bad_range, accept;

    // Encode the presented instruction and classify it as illegal or out of range
    always_comb begin
        word      = '0;
        illegal   = 1'b0;
        bad_range = 1'b0;
        case (in_kind)
            4'd0: word = {11'b10001011000, in_rm, 6'b0, in_rn, in_rd};
            4'd1: word = {11'b11001011000, in_rm, 6'b0, in_rn, in_rd};
            4'd2: word = {11'b10001010000, in_rm, 6'b0, in_rn, in_rd};
            4'd3: word = {11'b10101010000, in_rm, 6'b0, in_rn, in_rd};
            4'd4: begin
                word      = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
                bad_range = !((&in_imm[18:8]) || !(|in_imm[18:8]));
            end
            4'd5: begin
                word      = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
                bad_range = !((&in_imm[18:8]) || !(|in_imm[18:8]));
            end
            4'd6: word = {8'b10110100, in_imm, in_rd};
            4'd7: begin
                word      = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
                bad_range = |in_imm[18:12];
            end
            4'd8: begin
                word      = {10'b1101000100, in_imm[11:0], in_rn, in_rd};
                bad_range = |in_imm[18:12];
            end
            default: illegal = 1'b1;
        endcase
    end

    // A start pulse blocks acceptance in its own cycle
    assign in_ready = (state_q == LOAD) && (cnt_q < DEPTH_W) && !start;
    assign accept   = in_valid && in_ready;

    // Session control: restart, register the write of legal words, latch sticky errors
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_ill_d = err_ill_q;
        err_rng_d = err_rng_q;
        if (start) begin
            state_d   = LOAD;
            cnt_d     = '0;
            err_ill_d = 1'b0;
            err_rng_d = 1'b0;
        end else if (accept) begin
            if (illegal) begin
                err_ill_d = 1'b1;
            end else if (bad_range) begin
                err_rng_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q[AW-1:0];
                wr_data_d = word;
                cnt_d     = cnt_q + 1'b1;
            end
            if (in_last || cnt_d == DEPTH_W) state_d = DONE;
        end
    end

    // State and output registers; reset abandons any pending write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_ill_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_ill_q <= err_ill_d;
            err_rng_q <= err_rng_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign count       = cnt_q;
    assign done        = (state_q == DONE);
    assign err_illegal = err_ill_q;
    assign err_range   = err_rng_q;
endmodule
